// File: rtl/pipe_stage_reg.sv
`default_nettype none
// ============================================================================
//  Module   : pipe_stage_reg
//  Purpose  : Inter-stage pipeline register with a valid/ready handshake.
//             A two-entry skid buffer (main + skid) absorbs downstream
//             back-pressure, so in_ready depends on registered state only.
//             It also provides a synchronous flush that inserts a NOP bubble,
//             and saturating stall/bubble performance counters.
//  Ports    : clk        - rising-edge clock
//             rst        - asynchronous, active-low reset
//             in_valid   - upstream holds a valid entry
//             in_ready   - this stage accepts an entry this cycle
//             in_ctrl    - upstream control bundle
//             in_data    - upstream data payload
//             flush      - synchronous kill of all held entries
//             out_valid  - out_ctrl/out_data carry a live entry
//             out_ready  - downstream consumes this cycle
//             out_ctrl   - head control, NOP_CTRL when out_valid=0
//             out_data   - head payload (last value loaded into main)
//             cnt_clr    - synchronous clear of both counters
//             occupancy  - number of held entries (0..2)
//             stall_cnt  - cycles with out_valid & !out_ready (saturating)
//             bubble_cnt - cycles with out_valid=0 (saturating)
//  Revision : 1.0 - initial release
// ============================================================================
module pipe_stage_reg #(
    parameter int                CTRL_W   = 8,
    parameter int                DATA_W   = 64,
    parameter logic [CTRL_W-1:0] NOP_CTRL = {CTRL_W{1'b0}},
    parameter int                CNT_W    = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [CTRL_W-1:0] in_ctrl,
    input  logic [DATA_W-1:0] in_data,
    input  logic              flush,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [CTRL_W-1:0] out_ctrl,
    output logic [DATA_W-1:0] out_data,
    input  logic              cnt_clr,
    output logic [1:0]        occupancy,
    output logic [CNT_W-1:0]  stall_cnt,
    output logic [CNT_W-1:0]  bubble_cnt
);

    // State encoding doubles as the occupancy value.
    localparam logic [1:0] c_ST_EMPTY = 2'd0;
    localparam logic [1:0] c_ST_ONE   = 2'd1;
    localparam logic [1:0] c_ST_FULL  = 2'd2;

    logic [1:0]        r_state;
    logic [1:0]        w_next_state;

    logic [CTRL_W-1:0] r_main_ctrl;
    logic [DATA_W-1:0] r_main_data;
    logic [CTRL_W-1:0] r_skid_ctrl;
    logic [DATA_W-1:0] r_skid_data;

    logic [CNT_W-1:0]  r_stall_cnt;
    logic [CNT_W-1:0]  r_bubble_cnt;

    logic              w_acc;
    logic              w_con;
    logic              w_load_main_in;
    logic              w_load_main_skid;
    logic              w_load_skid_in;

    assign w_acc = in_valid & in_ready;
    assign w_con = out_valid & out_ready;

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= c_ST_EMPTY;
        end else begin
            r_state <= w_next_state;
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic; flush overrides everything and empties the stage.
    // ------------------------------------------------------------------
    always_comb begin
        w_next_state = r_state;
        if (flush) begin
            w_next_state = c_ST_EMPTY;
        end else begin
            case (r_state)
                c_ST_EMPTY: begin
                    if (w_acc) w_next_state = c_ST_ONE;
                end
                c_ST_ONE: begin
                    if (w_acc && !w_con)      w_next_state = c_ST_FULL;
                    else if (!w_acc && w_con) w_next_state = c_ST_EMPTY;
                end
                c_ST_FULL: begin
                    if (w_con) w_next_state = c_ST_ONE;
                end
                default: w_next_state = c_ST_EMPTY;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Output logic: all handshake outputs decode registered state only,
    // so there is no combinational out_ready -> in_ready path.
    // ------------------------------------------------------------------
    always_comb begin
        out_valid = 1'b0;
        in_ready  = 1'b1;
        occupancy = 2'd0;
        out_ctrl  = NOP_CTRL;
        case (r_state)
            c_ST_ONE: begin
                out_valid = 1'b1;
                occupancy = 2'd1;
                out_ctrl  = r_main_ctrl;
            end
            c_ST_FULL: begin
                out_valid = 1'b1;
                in_ready  = 1'b0;
                occupancy = 2'd2;
                out_ctrl  = r_main_ctrl;
            end
            default: begin
                out_valid = 1'b0;
                in_ready  = 1'b1;
                occupancy = 2'd0;
                out_ctrl  = NOP_CTRL;
            end
        endcase
    end

    assign out_data = r_main_data;

    // ------------------------------------------------------------------
    // Datapath load enables. A flush discards whatever would be loaded,
    // leaving the data registers at their previous contents.
    // ------------------------------------------------------------------
    assign w_load_main_in   = !flush && w_acc &&
                              ((r_state == c_ST_EMPTY) ||
                               ((r_state == c_ST_ONE) && w_con));
    assign w_load_skid_in   = !flush && w_acc && (r_state == c_ST_ONE) && !w_con;
    assign w_load_main_skid = !flush && w_con && (r_state == c_ST_FULL);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_main_ctrl <= '0;
            r_main_data <= '0;
            r_skid_ctrl <= '0;
            r_skid_data <= '0;
        end else begin
            if (w_load_main_in) begin
                r_main_ctrl <= in_ctrl;
                r_main_data <= in_data;
            end else if (w_load_main_skid) begin
                r_main_ctrl <= r_skid_ctrl;
                r_main_data <= r_skid_data;
            end
            if (w_load_skid_in) begin
                r_skid_ctrl <= in_ctrl;
                r_skid_data <= in_data;
            end
        end
    end

    // ------------------------------------------------------------------
    // Saturating performance counters. They sample the current
    // (pre-flush) out_valid, so a flush cycle is counted normally.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_stall_cnt  <= '0;
            r_bubble_cnt <= '0;
        end else if (cnt_clr) begin
            r_stall_cnt  <= '0;
            r_bubble_cnt <= '0;
        end else begin
            if (out_valid && !out_ready && (r_stall_cnt != {CNT_W{1'b1}})) begin
                r_stall_cnt <= r_stall_cnt + CNT_W'(1);
            end
            if (!out_valid && (r_bubble_cnt != {CNT_W{1'b1}})) begin
                r_bubble_cnt <= r_bubble_cnt + CNT_W'(1);
            end
        end
    end

    assign stall_cnt  = r_stall_cnt;
    assign bubble_cnt = r_bubble_cnt;

endmodule
`default_nettype wire

// File: tb/tb_pipe_stage_reg.sv
`default_nettype none
// ============================================================================
//  Module   : tb_pipe_stage_reg
//  Purpose  : Directed self-checking bench for pipe_stage_reg (CNT_W=4 so
//             counter saturation is reachable quickly).
//  Revision : 1.0 - initial release
// ============================================================================
module tb_pipe_stage_reg;

    localparam int CTRL_W = 8;
    localparam int DATA_W = 16;
    localparam int CNT_W  = 4;

    logic              clk;
    logic              rst;
    logic              in_valid;
    logic              in_ready;
    logic [CTRL_W-1:0] in_ctrl;
    logic [DATA_W-1:0] in_data;
    logic              flush;
    logic              out_valid;
    logic              out_ready;
    logic [CTRL_W-1:0] out_ctrl;
    logic [DATA_W-1:0] out_data;
    logic              cnt_clr;
    logic [1:0]        occupancy;
    logic [CNT_W-1:0]  stall_cnt;
    logic [CNT_W-1:0]  bubble_cnt;

    int errors = 0;
    int checks = 0;

    pipe_stage_reg #(
        .CTRL_W   (CTRL_W),
        .DATA_W   (DATA_W),
        .NOP_CTRL ({CTRL_W{1'b0}}),
        .CNT_W    (CNT_W)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_ctrl    (in_ctrl),
        .in_data    (in_data),
        .flush      (flush),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_ctrl   (out_ctrl),
        .out_data   (out_data),
        .cnt_clr    (cnt_clr),
        .occupancy  (occupancy),
        .stall_cnt  (stall_cnt),
        .bubble_cnt (bubble_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance one rising edge; outputs are sampled 1 time unit later.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [7:0] c, input logic [15:0] d);
        in_valid = v;
        in_ctrl  = c;
        in_data  = d;
    endtask

    initial begin
        rst       = 1'b0;
        in_valid  = 1'b0;
        in_ctrl   = '0;
        in_data   = '0;
        flush     = 1'b0;
        out_ready = 1'b0;
        cnt_clr   = 1'b0;
        #1;

        // ---------------- reset values ----------------
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_in_ready",  64'(in_ready),  64'd1);
        check("rst_occ",       64'(occupancy), 64'd0);
        check("rst_out_ctrl",  64'(out_ctrl),  64'h00);
        check("rst_out_data",  64'(out_data),  64'h0);
        check("rst_stall",     64'(stall_cnt), 64'd0);
        check("rst_bubble",    64'(bubble_cnt),64'd0);

        // release reset between edges
        @(posedge clk);
        #1;
        rst       = 1'b1;
        out_ready = 1'b1;

        // ---------------- idle: 10 bubble cycles ----------------
        for (int i = 0; i < 10; i++) step();
        check("idle_bubble", 64'(bubble_cnt), 64'd10);
        check("idle_stall",  64'(stall_cnt),  64'd0);
        check("idle_ctrl",   64'(out_ctrl),   64'h00);

        cnt_clr = 1'b1;
        step();
        cnt_clr = 1'b0;
        check("clr_bubble", 64'(bubble_cnt), 64'd0);

        // ---------------- stream A1..A8 with out_ready=1 ----------------
        // First edge is counted as a bubble (stage empty before A1 lands).
        for (int i = 1; i <= 8; i++) begin
            drive(1'b1, 8'(8'h10 + i), 16'(16'hA000 + i));
            check("stream_in_ready", 64'(in_ready), 64'd1);
            step();
            check("stream_valid", 64'(out_valid), 64'd1);
            check("stream_ctrl",  64'(out_ctrl),  64'(8'h10 + i));
            check("stream_data",  64'(out_data),  64'(16'hA000 + i));
            check("stream_occ",   64'(occupancy), 64'd1);
        end
        drive(1'b0, 8'h00, 16'h0);
        step();
        check("stream_drain_valid", 64'(out_valid),  64'd0);
        check("stream_no_gap",      64'(bubble_cnt), 64'd1);
        check("stream_no_stall",    64'(stall_cnt),  64'd0);

        // ---------------- skid: A1,A2,A3 with out_ready=0 from cycle 2 ----
        cnt_clr = 1'b1;
        drive(1'b1, 8'h21, 16'hB001);
        step();
        cnt_clr = 1'b0;
        check("skid_occ1", 64'(occupancy), 64'd1);
        out_ready = 1'b0;
        drive(1'b1, 8'h22, 16'hB002);
        step();
        check("skid_occ2",     64'(occupancy), 64'd2);
        check("skid_in_ready", 64'(in_ready),  64'd0);
        check("skid_head",     64'(out_ctrl),  64'h21);
        drive(1'b1, 8'h23, 16'hB003);
        step();
        step();
        check("skid_stall3",   64'(stall_cnt), 64'd3);
        check("skid_hold_occ", 64'(occupancy), 64'd2);
        check("skid_hold_hd",  64'(out_data),  64'hB001);
        out_ready = 1'b1;
        step();
        check("skid_a2_ctrl",  64'(out_ctrl),  64'h22);
        check("skid_a2_data",  64'(out_data),  64'hB002);
        check("skid_rec_occ",  64'(occupancy), 64'd1);
        check("skid_rec_rdy",  64'(in_ready),  64'd1);
        step();
        check("skid_a3_ctrl",  64'(out_ctrl),  64'h23);
        check("skid_a3_data",  64'(out_data),  64'hB003);
        drive(1'b0, 8'h00, 16'h0);
        step();
        check("skid_empty",    64'(occupancy), 64'd0);

        // ---------------- flush while FULL ----------------
        cnt_clr   = 1'b1;
        out_ready = 1'b0;
        drive(1'b1, 8'h31, 16'hC001);
        step();                             // B1 in, counters cleared
        cnt_clr = 1'b0;
        drive(1'b1, 8'h32, 16'hC002);
        step();                             // B2 in skid, stall=1
        check("fl_full", 64'(occupancy), 64'd2);
        drive(1'b1, 8'h33, 16'hC003);
        flush = 1'b1;
        check("fl_in_ready_cur", 64'(in_ready), 64'd0);
        step();                             // flush cycle counted: stall=2
        flush = 1'b0;
        drive(1'b0, 8'h00, 16'h0);
        check("fl_valid",  64'(out_valid),  64'd0);
        check("fl_occ",    64'(occupancy),  64'd0);
        check("fl_ctrl",   64'(out_ctrl),   64'h00);
        check("fl_stall",  64'(stall_cnt),  64'd2);
        check("fl_bubble", 64'(bubble_cnt), 64'd0);
        out_ready = 1'b1;
        step();
        check("fl_no_b3",     64'(out_valid),  64'd0);
        check("fl_bubble_1",  64'(bubble_cnt), 64'd1);

        // ---------------- flush & acc & con in ONE ----------------
        drive(1'b1, 8'h41, 16'hD001);
        step();
        check("fac_one", 64'(occupancy), 64'd1);
        drive(1'b1, 8'h42, 16'hD002);
        flush = 1'b1;
        step();
        flush = 1'b0;
        drive(1'b0, 8'h00, 16'h0);
        check("fac_empty", 64'(occupancy), 64'd0);
        check("fac_valid", 64'(out_valid), 64'd0);

        // ---------------- stall counter saturation ----------------
        cnt_clr = 1'b1;
        drive(1'b1, 8'h51, 16'hE001);
        step();
        cnt_clr = 1'b0;
        drive(1'b0, 8'h00, 16'h0);
        out_ready = 1'b0;
        for (int i = 0; i < 14; i++) step();
        check("sat_14", 64'(stall_cnt), 64'd14);
        for (int i = 0; i < 6; i++) step();
        check("sat_15", 64'(stall_cnt), 64'hF);
        check("sat_occ", 64'(occupancy), 64'd1);
        cnt_clr = 1'b1;
        step();
        cnt_clr = 1'b0;
        check("sat_clr", 64'(stall_cnt), 64'd0);
        step();
        check("sat_resume", 64'(stall_cnt), 64'd1);

        // ---------------- async reset while FULL ----------------
        drive(1'b1, 8'h52, 16'hE002);
        step();
        drive(1'b0, 8'h00, 16'h0);
        check("ar_full", 64'(occupancy), 64'd2);
        #2;
        rst = 1'b0;
        #1;
        check("ar_valid",  64'(out_valid),  64'd0);
        check("ar_ready",  64'(in_ready),   64'd1);
        check("ar_occ",    64'(occupancy),  64'd0);
        check("ar_ctrl",   64'(out_ctrl),   64'h00);
        check("ar_data",   64'(out_data),   64'h0);
        check("ar_stall",  64'(stall_cnt),  64'd0);
        #1;
        rst       = 1'b1;
        out_ready = 1'b1;
        drive(1'b1, 8'h61, 16'hF001);
        step();
        drive(1'b0, 8'h00, 16'h0);
        check("ar_c1_valid", 64'(out_valid), 64'd1);
        check("ar_c1_ctrl",  64'(out_ctrl),  64'h61);
        check("ar_c1_data",  64'(out_data),  64'hF001);
        step();
        check("ar_c1_gone",  64'(out_valid), 64'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    // Absolute time bound so the run always terminates.
    initial begin
        #100000;
        $display("FAIL timeout: observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
`default_nettype wire
